instr_cache: RTL

Direct-mapped instruction cache that answers the instruction fetcher's per-cycle fetch requests and refills from the memory controller on a miss. It sits between `instr_fetcher` (fetch side) and the memory controller (refill side). Each entry holds the 32 bits starting at one halfword-aligned PC, so compressed and straddling 32-bit instructions are served with no realignment logic in the fetcher.

---
 rtl/instr_cache_pkg.sv | 13 +
 rtl/instr_cache.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/instr_cache_pkg.sv
// rtl/instr_cache_pkg.sv - shared sizing and state encoding for instr_cache
package instr_cache_pkg;

  // Default index width: 2^6 entries, each one halfword-aligned 32-bit window.
  localparam int IC_INDEX_WIDTH = 6;

  typedef enum logic [1:0] {
    IC_IDLE  = 2'd0,
    IC_WAIT  = 2'd1,
    IC_READY = 2'd2
  } ic_state_e;

endpackage

// File: rtl/instr_cache.sv
// rtl/instr_cache.sv - direct-mapped instruction cache with single-miss refill (optional ICACHE_STATS_EN counters)
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int ICACHE_INDEX_WIDTH = IC_INDEX_WIDTH
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        need_flush_in,
  input  logic        is_stall_in,
  input  logic        fetch_enable_in,
  input  logic [31:0] pc_in,
  output logic        ic_hit,
  output logic        ic_miss_ready,
  output logic [31:0] ic_instr,
  output logic        ic2mc_valid,
  output logic [31:0] ic2mc_addr,
  input  logic        mc2ic_ready,
  input  logic [31:0] mc2ic_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] stat_hit_cnt,
  output logic [31:0] stat_miss_cnt
`endif
);

  localparam int IW      = ICACHE_INDEX_WIDTH;
  localparam int ENTRIES = 1 << IW;
  localparam int TAG_W   = 31 - IW;

  // Tag/data storage; only the valid bits need a reset.
  logic [TAG_W-1:0]   r_tag  [ENTRIES];
  logic [31:0]        r_data [ENTRIES];
  logic [ENTRIES-1:0] r_valid;

  ic_state_e   r_state;
  ic_state_e   w_next_state;
  logic [31:0] r_miss_pc;
  logic [31:0] r_miss_buf;
  logic        r_flushed;

  logic [IW-1:0]    w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [IW-1:0]    w_miss_idx;
  logic [TAG_W-1:0] w_miss_tag;
  logic             w_lookup_hit;
  logic             w_start_miss;
  logic             w_refill;
  logic             w_unused_pc_lsb;

  assign w_idx           = pc_in[IW:1];
  assign w_tag           = pc_in[31:IW+1];
  assign w_miss_idx      = r_miss_pc[IW:1];
  assign w_miss_tag      = r_miss_pc[31:IW+1];
  assign w_lookup_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // Fetch addresses are halfword aligned, so bit 0 never selects anything.
  assign w_unused_pc_lsb = pc_in[0];

  // Next-state decode plus the fetch/refill-facing outputs.
  always_comb begin
    w_next_state  = r_state;
    w_start_miss  = 1'b0;
    w_refill      = 1'b0;
    ic_hit        = 1'b0;
    ic_miss_ready = 1'b0;
    ic2mc_valid   = 1'b0;
    case (r_state)
      IC_IDLE: begin
        ic_hit = fetch_enable_in && w_lookup_hit;
        if (fetch_enable_in && !w_lookup_hit) begin
          w_start_miss = 1'b1;
          w_next_state = IC_WAIT;
        end
      end
      IC_WAIT: begin
        ic2mc_valid = 1'b1;
        if (mc2ic_ready) begin
          w_refill = 1'b1;
          // A flush arriving together with the data still cancels delivery.
          if (r_flushed || need_flush_in) begin
            w_next_state = IC_IDLE;
          end else begin
            w_next_state = IC_READY;
          end
        end
      end
      IC_READY: begin
        ic_miss_ready = 1'b1;
        if (need_flush_in || !is_stall_in) begin
          w_next_state = IC_IDLE;
        end
      end
      default: begin
        w_next_state = IC_IDLE;
      end
    endcase
    ic_instr   = ic_hit ? r_data[w_idx] : r_miss_buf;
    ic2mc_addr = r_miss_pc;
  end

  // State register, miss bookkeeping and valid bits; everything freezes while rdy_in is low.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state    <= IC_IDLE;
      r_valid    <= '0;
      r_miss_pc  <= '0;
      r_miss_buf <= '0;
      r_flushed  <= 1'b0;
    end else if (rdy_in) begin
      r_state <= w_next_state;
      if (w_start_miss) begin
        r_miss_pc <= pc_in;
        r_flushed <= 1'b0;
      end else if ((r_state == IC_WAIT) && need_flush_in) begin
        r_flushed <= 1'b1;
      end
      if (w_refill) begin
        r_valid[w_miss_idx] <= 1'b1;
        r_miss_buf          <= mc2ic_data;
        r_flushed           <= 1'b0;
      end
    end
  end

  // Refill write into the tag/data arrays at the latched miss index.
  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && w_refill) begin
      r_tag[w_miss_idx]  <= w_miss_tag;
      r_data[w_miss_idx] <= mc2ic_data;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Free-running hit/miss counters; a hit counts only when the fetcher takes it.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (rdy_in) begin
      if (ic_hit && !is_stall_in && !need_flush_in) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_start_miss) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign stat_hit_cnt  = r_hit_cnt;
  assign stat_miss_cnt = r_miss_cnt;
`endif

endmodule
